// File: rtl/life_gen_ctrl_if.sv
// rtl/life_gen_ctrl_if.sv - handshake bundle between the generation controller and the grid datapath
interface life_gen_ctrl_if;
    logic        grid_load;   // 1-cycle pulse: datapath loads load_data into the grid
    logic [63:0] load_data;   // seed value presented to the datapath
    logic        step_start;  // 1-cycle pulse: datapath begins the next generation
    logic        step_done;   // 1-cycle pulse: datapath finished the current generation

    modport master (
        output grid_load,
        output load_data,
        output step_start,
        input  step_done
    );

    modport slave (
        input  grid_load,
        input  load_data,
        input  step_start,
        output step_done
    );
endinterface

// File: rtl/life_gen_ctrl.sv
// rtl/life_gen_ctrl.sv - seed load / generation step sequencer for the 8x8 life grid datapath
module life_gen_ctrl #(
    parameter int RATE_DIV = 12500000,
    parameter int GEN_W    = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             switch1,
    input  logic             switch2,
    input  logic             load,
    input  logic [63:0]      seed,
    life_gen_ctrl_if.master  dp,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             err
);

    localparam int DIV_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_RUN_WAIT  = 3'd2;
    localparam logic [2:0] S_START     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic [TMO_W-1:0] tmo_q,   tmo_d;
    logic [GEN_W-1:0] gen_q,   gen_d;
    logic [63:0]      data_q,  data_d;
    logic             err_q,   err_d;
    logic             sw2_q;
    logic             step_req;

    // An edge is a single press; only IDLE consumes it, so it is never queued.
    assign step_req = switch2 & ~sw2_q;

    // Next-state and datapath-register update rules for each controller state.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        tmo_d   = tmo_q;
        gen_d   = gen_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    data_d  = seed;
                    state_d = S_LOAD;
                end else if (switch1) begin
                    div_d   = '0;
                    state_d = S_RUN_WAIT;
                end else if (step_req) begin
                    state_d = S_START;
                end
            end
            S_LOAD: begin
                gen_d   = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            S_RUN_WAIT: begin
                if (load) begin
                    data_d  = seed;
                    state_d = S_LOAD;
                end else if (!switch1) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                end else if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_START;
                end else begin
                    div_d   = div_q + 1'b1;
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // load and switch1 are deliberately not sampled here; the
                // datapath must finish (or time out) before anything else.
                if (dp.step_done) begin
                    gen_d = gen_q + 1'b1;
                    if (switch1) begin
                        div_d   = '0;
                        state_d = S_RUN_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any in-flight step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            tmo_q   <= '0;
            gen_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tmo_q   <= tmo_d;
            gen_q   <= gen_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // switch2 history for rising-edge detection, tracked in every state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw2_q <= 1'b0;
        end else begin
            sw2_q <= switch2;
        end
    end

    // Moore outputs decoded from the state register only.
    assign dp.grid_load  = (state_q == S_LOAD);
    assign dp.step_start = (state_q == S_START);
    assign dp.load_data  = data_q;
    assign busy          = (state_q == S_LOAD) || (state_q == S_START) ||
                           (state_q == S_WAIT_DONE);
    assign gen_count     = gen_q;
    assign err           = err_q;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb/tb_life_gen_ctrl.sv - randomized self-checking bench for life_gen_ctrl
module tb_life_gen_ctrl;

    localparam int RATE_DIV = 4;
    localparam int TIMEOUT  = 8;
    localparam int GEN_W    = 4;

    logic             clk     = 1'b0;
    logic             reset   = 1'b0;
    logic             switch1 = 1'b0;
    logic             switch2 = 1'b0;
    logic             load    = 1'b0;
    logic [63:0]      seed    = '0;
    logic [GEN_W-1:0] gen_count;
    logic             busy;
    logic             err;

    life_gen_ctrl_if dp();

    life_gen_ctrl #(
        .RATE_DIV (RATE_DIV),
        .GEN_W    (GEN_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .switch1   (switch1),
        .switch2   (switch2),
        .load      (load),
        .seed      (seed),
        .dp        (dp.master),
        .gen_count (gen_count),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: cycle index, responder schedule and expected generation count.
    int cyc       = 0;
    int resp_d    = 0;   // 0 = datapath never answers
    int done_at   = -1;
    int starts    = 0;
    int last_start = -1;
    int loads     = 0;
    int last_load = -1;
    int exp_gen   = 0;
    int start_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample outputs 1ns after the edge, then act as the datapath.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (dp.step_start) begin
            starts++;
            last_start = cyc;
            start_q.push_back(cyc);
            if (resp_d > 0) done_at = cyc + resp_d;
        end
        if (dp.grid_load) begin
            loads++;
            last_load = cyc;
        end
        if (done_at == cyc) begin
            dp.step_done = 1'b1;
            exp_gen = (exp_gen + 1) % (1 << GEN_W);
            done_at = -1;
        end else begin
            dp.step_done = 1'b0;
        end
    endtask

    task automatic settle();
        for (int i = 0; i < 60 && (busy || done_at >= 0); i++) cycle();
        cycle();
        check("settle_idle", busy, 1'b0);
    endtask

    initial begin
        int s0;
        int pc;
        int hold;
        int per;
        int l0;
        int sdone;
        logic [63:0] rseed;

        dp.step_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gen",   gen_count,     0);
        check("rst_busy",  busy,          0);
        check("rst_err",   err,           0);
        check("rst_gload", dp.grid_load,  0);
        check("rst_start", dp.step_start, 0);
        check("rst_data",  dp.load_data,  0);
        reset = 1'b1;
        cycle();

        // Fixed seed load: grid_load and busy for exactly one cycle.
        seed = 64'h0000_0018_1800_0000;
        load = 1'b1;
        cycle();
        load = 1'b0;
        check("load_pulse", dp.grid_load, 1);
        check("load_busy",  busy, 1);
        check("load_data",  dp.load_data, 64'h0000_0018_1800_0000);
        exp_gen = 0;
        cycle();
        check("load_pulse_end", dp.grid_load, 0);
        check("load_busy_end",  busy, 0);
        check("load_gen",       gen_count, 0);

        // Random loads.
        for (int k = 0; k < 3; k++) begin
            rseed = {$urandom, $urandom};
            seed = rseed;
            load = 1'b1;
            cycle();
            load = 1'b0;
            check("rload_pulse", dp.grid_load, 1);
            check("rload_data",  dp.load_data, rseed);
            cycle();
        end

        // Single-step presses with random hold and datapath latency.
        for (int p = 0; p < 5; p++) begin
            resp_d  = $urandom_range(1, TIMEOUT);
            hold    = $urandom_range(1, 10);
            s0      = starts;
            pc      = cyc;
            switch2 = 1'b1;
            for (int i = 0; i < hold; i++) cycle();
            switch2 = 1'b0;
            settle();
            check("step_count",   starts - s0, 1);
            check("step_latency", last_start - pc, 1);
            check("step_gen",     gen_count, exp_gen);
        end

        // Free-running mode: first step after RATE_DIV cycles, then a fixed period.
        resp_d = $urandom_range(1, 4);
        per    = 1 + resp_d + RATE_DIV;
        start_q.delete();
        pc      = cyc;
        switch1 = 1'b1;
        sdone   = 0;
        for (int i = 0; i < 600 && !sdone; i++) begin
            cycle();
            if (start_q.size() >= 20 && dp.step_done) sdone = 1;
        end
        check("run_reached", sdone, 1);
        if (start_q.size() > 0) check("run_first", start_q[0] - pc, RATE_DIV + 1);
        for (int i = 1; i < start_q.size(); i++)
            check("run_period", start_q[i] - start_q[i-1], per);
        // Now in the WAIT_DONE cycle carrying step_done; drop switch1 inside RUN_WAIT.
        hold = $urandom_range(1, RATE_DIV);
        for (int i = 0; i < hold; i++) cycle();
        switch1 = 1'b0;
        s0 = starts;
        for (int i = 0; i < 20; i++) cycle();
        check("run_stop",  starts - s0, 0);
        check("run_busy",  busy, 0);
        check("run_gen",   gen_count, exp_gen);

        // Timeout: datapath never answers.
        resp_d  = 0;
        switch2 = 1'b1;
        pc      = cyc;
        cycle();
        switch2 = 1'b0;
        check("tmo_start", last_start, pc + 1);
        for (int i = 0; i < TIMEOUT; i++) cycle();
        check("tmo_busy_last", busy, 1);
        check("tmo_err_early", err, 0);
        cycle();
        check("tmo_err",  err, 1);
        check("tmo_idle", busy, 0);
        check("tmo_gen",  gen_count, exp_gen);
        rseed = {$urandom, $urandom};
        seed  = rseed;
        load  = 1'b1;
        cycle();
        load  = 1'b0;
        check("tmo_load_pulse", dp.grid_load, 1);
        cycle();
        exp_gen = 0;
        check("tmo_err_clr", err, 0);
        check("tmo_gen_clr", gen_count, 0);

        // Load, switch1 and a switch2 edge together: load wins.
        s0      = starts;
        rseed   = {$urandom, $urandom};
        seed    = rseed;
        load    = 1'b1;
        switch1 = 1'b1;
        switch2 = 1'b1;
        cycle();
        load    = 1'b0;
        switch1 = 1'b0;
        check("pri_load",  dp.grid_load, 1);
        check("pri_nost",  dp.step_start, 0);
        check("pri_data",  dp.load_data, rseed);
        for (int i = 0; i < 10; i++) cycle();
        switch2 = 1'b0;
        check("pri_nostep", starts - s0, 0);
        cycle();

        // Load during WAIT_DONE is held off until step_done.
        resp_d  = 5;
        switch2 = 1'b1;
        cycle();
        switch2 = 1'b0;
        pc = last_start;
        cycle();
        cycle();
        l0    = loads;
        rseed = {$urandom, $urandom};
        seed  = rseed;
        load  = 1'b1;
        for (int i = 0; i < 20 && loads == l0; i++) cycle();
        load  = 1'b0;
        check("wload_latency", last_load - pc, resp_d + 2);
        cycle();
        exp_gen = 0;
        check("wload_gen",  gen_count, 0);
        check("wload_data", dp.load_data, rseed);
        cycle();

        // Reset in WAIT_DONE, then a stray step_done after release.
        resp_d  = 0;
        switch2 = 1'b1;
        cycle();
        switch2 = 1'b0;
        cycle();
        cycle();
        check("rstw_busy_pre", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rstw_busy", busy, 0);
        cycle();
        reset = 1'b1;
        exp_gen = 0;
        dp.step_done = 1'b1;
        s0 = starts;
        l0 = loads;
        cycle();
        for (int i = 0; i < 4; i++) cycle();
        check("rstw_gen",   gen_count, 0);
        check("rstw_busy2", busy, 0);
        check("rstw_err",   err, 0);
        check("rstw_data",  dp.load_data, 0);
        check("rstw_nost",  starts - s0, 0);
        check("rstw_nold",  loads - l0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_gen_ctrl.md
Name: life_gen_ctrl

Overview:
- Sequencing controller for the 64-bit seed/grid datapath (8x8 cell board).
- Loads a seed into the grid register.
- Issues generation-step commands, either free-running at a programmable rate (switch1) or one per press (switch2).
- Handshakes with the multi-cycle next-generation datapath, counts generations and flags a datapath timeout.

Parameters:
- RATE_DIV, 12500000, clock cycles spent in RUN_WAIT between steps in run mode (>=1)
- GEN_W, 16, width of generation counter
- TIMEOUT, 1024, max cycles in WAIT_DONE before error abort (>=2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- switch1  in  1  run-mode level (synchronous to clk)
- switch2  in  1  single-step button level (synchronous); rising edge requests one step
- load  in  1  seed-load request, level
- seed  in  64  seed value to load
- step_done  in  1  datapath finished current generation, 1-cycle pulse
- grid_load  out  1  1-cycle pulse: datapath loads load_data into grid
- load_data  out  64  registered copy of seed
- step_start  out  1  1-cycle pulse: datapath begins next generation
- gen_count  out  GEN_W  completed generations since last load
- busy  out  1  high in LOAD, START, WAIT_DONE
- err  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async): state IDLE; gen_count, divider, timeout counter, switch2 edge register, load_data, err all 0; all pulses low.
- States: IDLE, LOAD, RUN_WAIT, START, WAIT_DONE.
- Outputs are Moore-decoded from the state register:
  - grid_load=1 only in LOAD.
  - step_start=1 only in START.
  - busy as listed under Ports.
- Edge detect: sw2_q<=switch2 every cycle in all states; step request = switch2 & ~sw2_q. Edges are ignored outside IDLE and are never queued.
- IDLE, priority load > switch1 > step request:
  - load: capture seed into load_data, go to LOAD.
  - switch1: clear divider, go to RUN_WAIT.
  - step request: go to START.
  - otherwise stay in IDLE.
- LOAD: one cycle; gen_count<=0, err<=0; go to IDLE. Load held high re-triggers LOAD every other cycle; this is legal.
- RUN_WAIT, checks in order:
  - load: capture seed, go to LOAD.
  - ~switch1: go to IDLE, clear divider.
  - divider==RATE_DIV-1: clear divider, go to START.
  - otherwise divider+1.
  - Exactly RATE_DIV cycles are spent in RUN_WAIT per step.
- START: one cycle; clear timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - step_done: gen_count<=gen_count+1 (wraps mod 2^GEN_W); go to RUN_WAIT if switch1 (divider cleared), else IDLE.
  - Else timeout counter +1; when it reaches TIMEOUT-1 without step_done, set err=1 and go to IDLE (gen_count unchanged).
  - load and switch1 changes are not acted on in WAIT_DONE; a load still held on exit is served from IDLE/RUN_WAIT.
- step_done is ignored in every state except WAIT_DONE, including the START cycle.
- Latency:
  - load seen in IDLE at cycle N -> grid_load high at N+1.
  - step edge at N -> step_start at N+1.
- err clears only on reset or LOAD.
- Reset mid-step: abort immediately; any in-flight step_done after reset release is ignored (state IDLE).

Test Plan (RATE_DIV=4, TIMEOUT=8, GEN_W=4):
- Reset then load=1 for 1 cycle, seed=64'h0000_0018_1800_0000 -> grid_load pulse next cycle, load_data=seed, gen_count=0, busy high one cycle.
- switch2 0->1 held 10 cycles, datapath returns step_done 2 cycles after step_start -> exactly one step_start, gen_count=1, back to IDLE; a second press gives gen_count=2.
- switch1=1 held, step_done on 2nd WAIT_DONE cycle -> step_start period 7 cycles, gen_count 1,2,3...; gen_count wraps 15->0; drop switch1 during RUN_WAIT -> IDLE within 1 cycle, no further steps.
- Never return step_done -> err=1 after 8 WAIT_DONE cycles, state IDLE, gen_count unchanged; then load -> err=0.
- Simultaneous load, switch1 and switch2 edge in IDLE -> LOAD wins, no step_start; load asserted during WAIT_DONE -> ignored until step_done, then LOAD.
- Assert reset in WAIT_DONE, release, pulse step_done -> gen_count stays 0, no outputs asserted.
